// File: rtl/instr_mem_loader.sv
// Program loader: assembles a big-endian byte stream into 16-bit words and
// writes them to instruction memory at addresses 0..N-1 while holding the CPU.
module instr_mem_loader #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   input  logic              abort,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HI,
      S_LO,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [7:0]        hi_q, hi_d;
   logic [7:0]        lo_q, lo_d;
   logic              err_q, err_d;
   logic              last_word;

   assign last_word = ({1'b0, addr_q} == (count_q - CNT_ONE));

   always_comb begin
      // NOTE: every _d gets a default first so no path through the case
      // leaves a variable unassigned, which would infer a latch.
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if ((word_count == '0) || (word_count > DEPTH_C)) begin
                  err_d = 1'b1;
               end else begin
                  count_d = word_count;
                  addr_d  = '0;
                  state_d = S_HI;
               end
            end
         end
         S_HI: begin
            if (abort) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (byte_valid) begin
               hi_d    = byte_data;
               state_d = S_LO;
            end
         end
         S_LO: begin
            if (abort) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (byte_valid) begin
               lo_d    = byte_data;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            // The write strobe is decoded from state, so it still fires here on abort.
            if (abort) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (last_word) begin
               state_d = S_DONE;
            end else begin
               addr_d  = addr_q + ADDR_ONE;
               state_d = S_HI;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         err_q   <= err_d;
      end
   end

   assign byte_ready = (state_q == S_HI) || (state_q == S_LO);
   assign wr_en      = (state_q == S_WRITE);
   assign wr_addr    = addr_q;
   assign wr_data    = {hi_q, lo_q};
   assign busy       = (state_q != S_IDLE);
   assign cpu_hold   = busy;
   assign done       = (state_q == S_DONE);
   assign err        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: per-scenario tasks with inline checks
// against hand-computed write logs, pulse counts and timing.
module tb_instr_mem_loader;

   logic       clk;
   logic       rst;
   logic       start;
   logic [4:0] word_count;
   logic       abort;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [15:0] wr_data;
   logic       cpu_hold;
   logic       busy;
   logic       done;
   logic       err;

   instr_mem_loader #(.DATA_W(16), .ADDR_W(4), .DEPTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .word_count (word_count),
      .abort      (abort),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [7:0]  stream [0:63];
   logic [3:0]  log_addr [0:127];
   logic [15:0] log_data [0:127];
   int wr_cnt     = 0;
   int err_cnt    = 0;
   int done_cnt   = 0;
   int cyc        = 0;
   int busy_rise  = 0;
   int done_cyc   = 0;
   int hold_bad   = 0;
   int ready_bad  = 0;
   logic busy_prev = 1'b0;

   // Event log sampled on the falling edge, half a cycle away from DUT updates.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      busy_prev <= busy;
      if (wr_en) begin
         log_addr[wr_cnt] <= wr_addr;
         log_data[wr_cnt] <= wr_data;
         wr_cnt <= wr_cnt + 1;
      end
      if (err) err_cnt <= err_cnt + 1;
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (busy && !busy_prev) busy_rise <= cyc;
      if (cpu_hold !== busy) hold_bad <= hold_bad + 1;
      if (byte_ready && wr_en) ready_bad <= ready_bad + 1;
   end

   // Entered and left on a falling edge; start is seen by the DUT at the rising edge between.
   task automatic do_start(input logic [4:0] wc);
      start      = 1'b1;
      word_count = wc;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic feed(input int first, input int n, input int gap);
      bit got;
      bit timed_out;
      int waits;
      timed_out = 1'b0;
      for (int i = 0; i < n && !timed_out; i++) begin
         for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            @(negedge clk);
         end
         byte_valid = 1'b1;
         byte_data  = stream[first + i];
         got   = 1'b0;
         waits = 0;
         while (!got && waits < 50) begin
            got = byte_ready;
            @(negedge clk);
            waits++;
         end
         if (!got) timed_out = 1'b1;
      end
      byte_valid = 1'b0;
      total_cnt++;
      if (timed_out) $display("FAIL feed_timeout: byte_ready never seen, bytes from %0d", first);
      else pass_cnt++;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (done) seen = 1'b1;
         else @(negedge clk);
      end
      total_cnt++;
      if (!seen) $display("FAIL %s_done_timeout: done=0 required 1", name);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({byte_ready, wr_en, cpu_hold, busy, done, err, wr_addr, wr_data} !== '0)
         $display("FAIL reset_outputs: got %b_%b_%b_%b_%b_%b addr=%h data=%h required all 0",
                  byte_ready, wr_en, cpu_hold, busy, done, err, wr_addr, wr_data);
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int base_w, base_e, base_d;
      logic [15:0] exp_data [0:2];
      exp_data[0] = 16'h0400; exp_data[1] = 16'h0441; exp_data[2] = 16'h2050;
      base_w = wr_cnt; base_e = err_cnt; base_d = done_cnt;
      do_start(5'd3);
      feed(0, 6, 0);
      wait_done("basic");
      total_cnt++;
      if (wr_cnt - base_w !== 3) $display("FAIL basic_write_count: got %0d required 3", wr_cnt - base_w);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         total_cnt++;
         if (log_addr[base_w + i] !== 4'(i) || log_data[base_w + i] !== exp_data[i])
            $display("FAIL basic_write%0d: got addr=%h data=%h required addr=%h data=%h",
                     i, log_addr[base_w + i], log_data[base_w + i], i, exp_data[i]);
         else pass_cnt++;
      end
      // HI is the first busy cycle; done is the (3N+1)th cycle.
      total_cnt++;
      if (done_cyc - busy_rise !== 9)
         $display("FAIL basic_done_latency: got %0d required 9", done_cyc - busy_rise);
      else pass_cnt++;
      total_cnt++;
      if (cpu_hold !== 1'b0 || busy !== 1'b0)
         $display("FAIL basic_hold_release: got hold=%b busy=%b required 0 0", cpu_hold, busy);
      else pass_cnt++;
      total_cnt++;
      if (done_cnt - base_d !== 1 || err_cnt - base_e !== 0 || hold_bad !== 0)
         $display("FAIL basic_pulses: got done=%0d err=%0d hold_bad=%0d required 1 0 0",
                  done_cnt - base_d, err_cnt - base_e, hold_bad);
      else pass_cnt++;
   endtask

   task automatic test_throttled();
      int base_w;
      logic [15:0] exp_data [0:2];
      exp_data[0] = 16'h0400; exp_data[1] = 16'h0441; exp_data[2] = 16'h2050;
      base_w = wr_cnt;
      do_start(5'd3);
      feed(0, 6, 2);
      wait_done("throttled");
      total_cnt++;
      if (wr_cnt - base_w !== 3) $display("FAIL throttled_write_count: got %0d required 3", wr_cnt - base_w);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         total_cnt++;
         if (log_addr[base_w + i] !== 4'(i) || log_data[base_w + i] !== exp_data[i])
            $display("FAIL throttled_write%0d: got addr=%h data=%h required addr=%h data=%h",
                     i, log_addr[base_w + i], log_data[base_w + i], i, exp_data[i]);
         else pass_cnt++;
      end
      total_cnt++;
      if (ready_bad !== 0) $display("FAIL throttled_ready_in_write: got %0d cycles required 0", ready_bad);
      else pass_cnt++;
   endtask

   task automatic test_full_and_reject();
      int base_w, base_e;
      bit words_ok;
      base_w = wr_cnt;
      do_start(5'd16);
      feed(8, 32, 0);
      wait_done("full");
      repeat (4) @(negedge clk);
      total_cnt++;
      if (wr_cnt - base_w !== 16) $display("FAIL full_write_count: got %0d required 16", wr_cnt - base_w);
      else pass_cnt++;
      words_ok = 1'b1;
      for (int i = 0; i < 16; i++)
         if (log_addr[base_w + i] !== 4'(i) || log_data[base_w + i] !== 16'(i)) words_ok = 1'b0;
      total_cnt++;
      if (!words_ok) $display("FAIL full_words: got a write off the addr i / data i pattern, required all match");
      else pass_cnt++;
      total_cnt++;
      if (log_addr[base_w + 15] !== 4'hF || log_data[base_w + 15] !== 16'h000F)
         $display("FAIL full_last_write: got addr=%h data=%h required f 000f",
                  log_addr[base_w + 15], log_data[base_w + 15]);
      else pass_cnt++;

      base_w = wr_cnt;
      for (int k = 0; k < 2; k++) begin
         base_e = err_cnt;
         do_start(k == 0 ? 5'd17 : 5'd0);
         total_cnt++;
         if (err !== 1'b1 || busy !== 1'b0)
            $display("FAIL reject%0d_err: got err=%b busy=%b required 1 0", k, err, busy);
         else pass_cnt++;
         @(negedge clk);
         total_cnt++;
         if (err !== 1'b0 || busy !== 1'b0)
            $display("FAIL reject%0d_after: got err=%b busy=%b required 0 0", k, err, busy);
         else pass_cnt++;
      end
      total_cnt++;
      if (wr_cnt - base_w !== 0) $display("FAIL reject_no_write: got %0d writes required 0", wr_cnt - base_w);
      else pass_cnt++;
   endtask

   task automatic test_abort();
      int base_w;
      base_w = wr_cnt;
      do_start(5'd3);
      feed(0, 3, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total_cnt++;
      if (err !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0)
         $display("FAIL abort_state: got err=%b busy=%b hold=%b required 1 0 0", err, busy, cpu_hold);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (wr_cnt - base_w !== 1 || log_addr[base_w] !== 4'h0 || log_data[base_w] !== 16'h0400)
         $display("FAIL abort_writes: got n=%0d addr=%h data=%h required 1 0 0400",
                  wr_cnt - base_w, log_addr[base_w], log_data[base_w]);
      else pass_cnt++;

      base_w = wr_cnt;
      do_start(5'd3);
      feed(0, 6, 0);
      wait_done("reload");
      total_cnt++;
      if (wr_cnt - base_w !== 3 || log_addr[base_w] !== 4'h0 || log_data[base_w + 2] !== 16'h2050)
         $display("FAIL abort_reload: got n=%0d first_addr=%h last_data=%h required 3 0 2050",
                  wr_cnt - base_w, log_addr[base_w], log_data[base_w + 2]);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      int base_w;
      do_start(5'd1);
      feed(0, 1, 0);
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if ({byte_ready, wr_en, cpu_hold, busy, done, err, wr_addr, wr_data} !== '0)
         $display("FAIL async_reset_outputs: got rdy=%b hold=%b busy=%b data=%h required all 0",
                  byte_ready, cpu_hold, busy, wr_data);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (busy !== 1'b0 || byte_ready !== 1'b0)
         $display("FAIL async_reset_idle: got busy=%b rdy=%b required 0 0", busy, byte_ready);
      else pass_cnt++;
      base_w = wr_cnt;
      do_start(5'd1);
      feed(2, 2, 0);
      wait_done("post_reset");
      total_cnt++;
      if (wr_cnt - base_w !== 1 || log_addr[base_w] !== 4'h0 || log_data[base_w] !== 16'h0441)
         $display("FAIL async_reset_reload: got n=%0d addr=%h data=%h required 1 0 0441",
                  wr_cnt - base_w, log_addr[base_w], log_data[base_w]);
      else pass_cnt++;
   endtask

   task automatic test_start_while_busy();
      int base_w, base_e;
      base_w = wr_cnt; base_e = err_cnt;
      do_start(5'd2);
      feed(0, 2, 0);
      // A latched count of 1 here would end the load after one word.
      start      = 1'b1;
      word_count = 5'd1;
      @(negedge clk);
      start      = 1'b0;
      feed(2, 2, 0);
      wait_done("busy_start");
      total_cnt++;
      if (wr_cnt - base_w !== 2 || log_data[base_w + 1] !== 16'h0441 || log_addr[base_w + 1] !== 4'h1)
         $display("FAIL busy_start_writes: got n=%0d addr1=%h data1=%h required 2 1 0441",
                  wr_cnt - base_w, log_addr[base_w + 1], log_data[base_w + 1]);
      else pass_cnt++;
      total_cnt++;
      if (err_cnt - base_e !== 0) $display("FAIL busy_start_err: got %0d err pulses required 0", err_cnt - base_e);
      else pass_cnt++;
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      word_count = '0;
      abort      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = '0;
      stream[0] = 8'h04; stream[1] = 8'h00; stream[2] = 8'h04;
      stream[3] = 8'h41; stream[4] = 8'h20; stream[5] = 8'h50;
      for (int w = 0; w < 16; w++) begin
         stream[8 + 2 * w] = 8'h00;
         stream[9 + 2 * w] = 8'(w);
      end
      @(negedge clk);
      test_reset();
      test_basic();
      test_throttled();
      test_full_and_reject();
      test_abort();
      test_async_reset();
      test_start_while_busy();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
